invader_fire_scheduler: RTL and testbench

- Decides when invaders shoot, which column shoots, and which missile slot receives the shot.
- Sits between the invader-grid state (alive mask) and the invader-missile datapath.
- Issues one fire request at a time on a valid/ready handshake. The datapath spawns the missile above the bottom-most live invader of the granted column.

---
 rtl/invader_fire_scheduler.sv | 196 +++++++++++++++++++
 tb/tb_invader_fire_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/invader_fire_scheduler.sv
// Invader fire scheduler: chooses the shooting column, its bottom live row and a free missile slot.
// Optional FIRE_LFSR_EN seeds each scan's start column from a 16-bit LFSR.
module invader_fire_scheduler #(
  parameter int unsigned NUM_COLS        = 11,
  parameter int unsigned NUM_ROWS        = 5,
  parameter int unsigned NUM_SLOTS       = 3,
  parameter int unsigned COOLDOWN_FRAMES = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         enable,
  input  logic                         frame,
  input  logic [NUM_COLS*NUM_ROWS-1:0] alive,
  input  logic [NUM_SLOTS-1:0]         slot_free,
  input  logic                         fire_ready,
  output logic                         fire_valid,
  output logic [1:0]                   fire_slot,
  output logic [3:0]                   fire_col,
  output logic [2:0]                   fire_row
);

  localparam int unsigned    CdW      = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [CdW-1:0] CdReload = CdW'(COOLDOWN_FRAMES);
  localparam logic [3:0]     LastCol  = 4'(NUM_COLS - 1);

  typedef enum logic [1:0] {StWait, StScan, StRow, StIssue} state_e;

  state_e         state_q, state_d;
  logic [CdW-1:0] cooldown_q, cooldown_d;
  logic [3:0]     col_ptr_q, col_ptr_d;
  logic [3:0]     scan_cnt_q, scan_cnt_d;
  logic           fire_valid_q, fire_valid_d;
  logic [1:0]     fire_slot_q, fire_slot_d;
  logic [3:0]     fire_col_q, fire_col_d;
  logic [2:0]     fire_row_q, fire_row_d;

  logic [15:0]         col_any;
  logic [NUM_ROWS-1:0] sel_rows;
  logic [2:0]          bottom_row;
  logic [3:0]          slot_pad;
  logic [1:0]          free_idx;

`ifdef FIRE_LFSR_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Right-shifting Fibonacci form of taps 16,14,13,11.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else if (clear) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
    end
  end
`endif

  always_comb begin
    col_any  = '0;
    sel_rows = '0;
    for (int unsigned c = 0; c < NUM_COLS; c++) begin
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
        col_any[c] = col_any[c] | alive[r*NUM_COLS + c];
        if (fire_col_q == 4'(c)) sel_rows[r] = alive[r*NUM_COLS + c];
      end
    end
  end

  // Highest row index wins: it is the invader nearest the player.
  always_comb begin
    bottom_row = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (sel_rows[r]) bottom_row = 3'(r);
    end
  end

  always_comb begin
    slot_pad = '0;
    free_idx = '0;
    for (int n = NUM_SLOTS - 1; n >= 0; n--) begin
      if (slot_free[n]) free_idx = 2'(n);
    end
    for (int unsigned n = 0; n < NUM_SLOTS; n++) begin
      slot_pad[n] = slot_free[n];
    end
  end

  always_comb begin
    state_d      = state_q;
    cooldown_d   = cooldown_q;
    col_ptr_d    = col_ptr_q;
    scan_cnt_d   = scan_cnt_q;
    fire_valid_d = fire_valid_q;
    fire_slot_d  = fire_slot_q;
    fire_col_d   = fire_col_q;
    fire_row_d   = fire_row_q;

    if (!enable) begin
      state_d      = StWait;
      fire_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StWait: begin
          if (cooldown_q != '0) begin
            if (frame) cooldown_d = cooldown_q - CdW'(1);
          end else if (|slot_free) begin
            fire_slot_d = free_idx;
            scan_cnt_d  = '0;
            state_d     = StScan;
`ifdef FIRE_LFSR_EN
            col_ptr_d   = 4'(lfsr_q % 16'(NUM_COLS));
`endif
          end
        end
        StScan: begin
          if (col_any[col_ptr_q]) begin
            fire_col_d = col_ptr_q;
            state_d    = StRow;
          end else begin
            col_ptr_d  = (col_ptr_q == LastCol) ? 4'd0 : col_ptr_q + 4'd1;
            scan_cnt_d = scan_cnt_q + 4'd1;
            if (scan_cnt_q == LastCol) begin
              cooldown_d = CdReload;
              state_d    = StWait;
            end
          end
        end
        StRow: begin
          col_ptr_d = (fire_col_q == LastCol) ? 4'd0 : fire_col_q + 4'd1;
          if (|sel_rows) begin
            fire_row_d   = bottom_row;
            fire_valid_d = 1'b1;
            state_d      = StIssue;
          end else begin
            // Column emptied since the scan hit; retry straight away.
            cooldown_d = '0;
            state_d    = StWait;
          end
        end
        StIssue: begin
          if (fire_ready) begin
            fire_valid_d = 1'b0;
            cooldown_d   = CdReload;
            state_d      = StWait;
          end else if (!slot_pad[fire_slot_q]) begin
            fire_valid_d = 1'b0;
            cooldown_d   = '0;
            state_d      = StWait;
          end
        end
        default: state_d = StWait;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StWait;
      cooldown_q   <= CdReload;
      col_ptr_q    <= '0;
      scan_cnt_q   <= '0;
      fire_valid_q <= 1'b0;
      fire_slot_q  <= '0;
      fire_col_q   <= '0;
      fire_row_q   <= '0;
    end else if (clear) begin
      state_q      <= StWait;
      cooldown_q   <= CdReload;
      col_ptr_q    <= '0;
      scan_cnt_q   <= '0;
      fire_valid_q <= 1'b0;
      fire_slot_q  <= '0;
      fire_col_q   <= '0;
      fire_row_q   <= '0;
    end else begin
      state_q      <= state_d;
      cooldown_q   <= cooldown_d;
      col_ptr_q    <= col_ptr_d;
      scan_cnt_q   <= scan_cnt_d;
      fire_valid_q <= fire_valid_d;
      fire_slot_q  <= fire_slot_d;
      fire_col_q   <= fire_col_d;
      fire_row_q   <= fire_row_d;
    end
  end

  assign fire_valid = fire_valid_q;
  assign fire_slot  = fire_slot_q;
  assign fire_col   = fire_col_q;
  assign fire_row   = fire_row_q;

endmodule

// File: tb/tb_invader_fire_scheduler.sv
// Randomized bench for invader_fire_scheduler against a shot-level reference model.
module tb_invader_fire_scheduler;

  localparam int NC = 11;
  localparam int NR = 5;
  localparam int NS = 3;
  localparam int CD = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           clear;
  logic           enable;
  logic           frame;
  logic [NC*NR-1:0] alive;
  logic [NS-1:0]  slot_free;
  logic           fire_ready;
  logic           fire_valid;
  logic [1:0]     fire_slot;
  logic [3:0]     fire_col;
  logic [2:0]     fire_row;

  int n_checks = 0;
  int n_fails  = 0;
  int m_cd;   // cooldown frames still owed before the next launch
  int m_ptr;  // round-robin start column

  always #5 clk = ~clk;

  invader_fire_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .enable    (enable),
    .frame     (frame),
    .alive     (alive),
    .slot_free (slot_free),
    .fire_ready(fire_ready),
    .fire_valid(fire_valid),
    .fire_slot (fire_slot),
    .fire_col  (fire_col),
    .fire_row  (fire_row)
  );

`ifdef FIRE_LFSR_EN
  logic [15:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst)        m_lfsr <= 16'hACE1;
    else if (clear) m_lfsr <= 16'hACE1;
    else            m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
  end
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int start_col();
`ifdef FIRE_LFSR_EN
    return int'(m_lfsr % 16'(NC));
`else
    return m_ptr;
`endif
  endfunction

  function automatic bit col_live(input logic [NC*NR-1:0] a, input int c);
    for (int r = 0; r < NR; r++) if (a[r*NC + c]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int bottom_row(input logic [NC*NR-1:0] a, input int c);
    int b = 0;
    for (int r = 0; r < NR; r++) if (a[r*NC + c]) b = r;
    return b;
  endfunction

  function automatic int lowest_free(input logic [NS-1:0] sf);
    for (int n = 0; n < NS; n++) if (sf[n]) return n;
    return 0;
  endfunction

  task automatic do_reset();
    rst = 1'b1; clear = 1'b0; enable = 1'b1; frame = 1'b0; fire_ready = 1'b0;
    #1;
    check("rst_valid", 32'(fire_valid), 0);
    check("rst_slot", 32'(fire_slot), 0);
    check("rst_col", 32'(fire_col), 0);
    check("rst_row", 32'(fire_row), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_cd = CD;
    m_ptr = 0;
  endtask

  task automatic run_cooldown();
    while (m_cd > 0) begin
      repeat ($urandom_range(0, 2)) begin
        step();
        check("cd_idle", 32'(fire_valid), 0);
      end
      if ($urandom_range(0, 4) == 0) begin
        enable = 1'b0; frame = 1'b1;
        step();
        enable = 1'b1; frame = 1'b0;
        check("cd_disabled", 32'(fire_valid), 0);
      end else begin
        frame = 1'b1;
        step();
        frame = 1'b0;
        m_cd--;
        check("cd_frame", 32'(fire_valid), 0);
      end
    end
  endtask

  // DUT is idle with cooldown spent; the next edge launches a scan.
  task automatic expect_shot(output bit found, output int e_slot, output int e_col,
                             output int e_row);
    int s, d, n;
    s = start_col();
    e_col = -1;
    d = 0;
    for (int i = 0; i < NC; i++) begin
      if (e_col < 0 && col_live(alive, (s + i) % NC)) begin
        e_col = (s + i) % NC;
        d = i;
      end
    end
    e_slot = lowest_free(slot_free);
    e_row = 0;
    n = 0;
    if (e_col < 0) begin
      found = 1'b0;
      repeat (NC + 8) begin
        step();
        if (fire_valid === 1'b1) n++;
      end
      check("empty_no_fire", 32'(n), 0);
      return;
    end
    found = 1'b1;
    e_row = bottom_row(alive, e_col);
    while (fire_valid !== 1'b1 && n < NC + 10) begin
      step();
      n++;
    end
    check("latency", 32'(n), 32'(3 + d));
    check("slot", 32'(fire_slot), 32'(e_slot));
    check("col", 32'(fire_col), 32'(e_col));
    check("row", 32'(fire_row), 32'(e_row));
    m_ptr = (e_col + 1) % NC;
  endtask

  // res: 0 transfer, 1 withdraw, 2 disable, 3 clear
  task automatic episode(input logic [NC*NR-1:0] a, input logic [NS-1:0] sf, input int stall,
                         input int hold, input int res);
    bit found;
    int es, ec, er;
    alive = a;
    slot_free = sf;
    fire_ready = 1'b0;
    run_cooldown();
    if (stall > 0) begin
      slot_free = '0;
      repeat (stall) begin
        step();
        check("stall", 32'(fire_valid), 0);
      end
      slot_free = sf;
    end
    expect_shot(found, es, ec, er);
    if (!found) begin
      m_cd = CD;
      return;
    end
    repeat (hold) begin
      frame = 1'b1;
      step();
      frame = 1'b0;
      check("hold_valid", 32'(fire_valid), 1);
      check("hold_slot", 32'(fire_slot), 32'(es));
      check("hold_col", 32'(fire_col), 32'(ec));
      check("hold_row", 32'(fire_row), 32'(er));
    end
    case (res)
      0: begin
        fire_ready = 1'b1;
        step();
        fire_ready = 1'b0;
        check("xfer_drop", 32'(fire_valid), 0);
        m_cd = CD;
      end
      1: begin
        slot_free[es] = 1'b0;
        step();
        check("withdraw_drop", 32'(fire_valid), 0);
        m_cd = 0;
      end
      2: begin
        enable = 1'b0;
        step();
        check("disable_drop", 32'(fire_valid), 0);
        repeat ($urandom_range(0, 3)) begin
          frame = 1'($urandom_range(0, 1));
          step();
          frame = 1'b0;
          check("disabled_idle", 32'(fire_valid), 0);
        end
        enable = 1'b1;
      end
      default: begin
        clear = 1'b1;
        fire_ready = 1'b1;
        step();
        clear = 1'b0;
        fire_ready = 1'b0;
        check("clr_valid", 32'(fire_valid), 0);
        check("clr_slot", 32'(fire_slot), 0);
        check("clr_col", 32'(fire_col), 0);
        check("clr_row", 32'(fire_row), 0);
        m_cd = CD;
        m_ptr = 0;
      end
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC*NR-1:0] all_alive;
    logic [NC*NR-1:0] col7;
    logic [NC*NR-1:0] ra;
    logic [63:0]      r1;
    logic [63:0]      r2;
    int               mode;
    int               rc;
    int               rr;

    all_alive = '1;
    col7 = '0;
    for (int r = 0; r < 3; r++) col7[r*NC + 7] = 1'b1;
    alive = '0;
    slot_free = '1;
    do_reset();

    episode(all_alive, 3'b111, 0, 0, 0);
    episode(all_alive, 3'b111, 0, 0, 0);

    do_reset();
    episode(col7, 3'b100, 0, 5, 1);

    // Async reset while the scan is still walking toward column 10.
    alive = '0;
    alive[4*NC + 10] = 1'b1;
    slot_free = 3'b100;
    step();
    step();
    #2;
    do_reset();

    episode('0, 3'b111, 0, 0, 0);
    episode(all_alive, 3'b011, 2, 0, 0);
    episode(all_alive, 3'b110, 0, 1, 3);
    episode(all_alive, 3'b111, 0, 0, 0);

    for (int k = 0; k < 40; k++) begin
      mode = $urandom_range(0, 9);
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      if (mode == 0) begin
        ra = '0;
      end else if (mode <= 2) begin
        ra = '0;
        rc = $urandom_range(0, NC - 1);
        for (int r = 0; r < NR; r++) if ($urandom_range(0, 1) == 1) ra[r*NC + rc] = 1'b1;
        ra[$urandom_range(0, NR - 1)*NC + rc] = 1'b1;
      end else if (mode <= 5) begin
        ra = r1[NC*NR-1:0] & r2[NC*NR-1:0] & {r1[31:0], r2[NC*NR-33:0]};
      end else begin
        ra = r1[NC*NR-1:0];
      end
      rr = $urandom_range(0, 9);
      episode(ra, 3'($urandom_range(1, 7)),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
              $urandom_range(0, 4),
              (rr <= 4) ? 0 : (rr <= 6) ? 1 : (rr <= 8) ? 2 : 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
